// File: rtl/serial_bus_pkg.sv
// Shared types and constants for the serial bus sequencer.
// FSM states, beat counts and the latched transaction bundle.
package serial_bus_pkg;

  localparam int LANE_W     = 8;
  localparam int ADDR_BEATS = 4;
  localparam int DATA_BEATS = 4;
  localparam int CMD_WRITE  = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CMD,
    S_WAIT,
    S_DATA,
    S_DONE
  } state_t;

  typedef struct packed {
    logic        id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

endpackage

// File: rtl/serial_bus_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter with last-granted pointer.
// Pointer resets to requester 1 so requester 0 wins the first tie.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic gnt,
  output logic gnt_id
);

  logic last;

  // Sole requester wins; on a tie the one not granted last wins
  always_comb begin
    gnt    = req0 | req1;
    gnt_id = (req0 & req1) ? ~last : req1;
  end

  // Remember who was granted when the grant is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last <= 1'b1;
    else if (take && gnt)
      last <= gnt_id;
  end

endmodule

// File: rtl/serial_bus_sequencer.sv
// Serial bus sequencer: arbitrates two requesters and runs
// ADDR/CMD/WAIT/DATA/DONE beats over byte-wide pad lanes.
module serial_bus_sequencer
  import serial_bus_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic [7:0]  pad_ctl,
  output logic [7:0]  pad_dout,
  output logic [7:0]  pad_oe,
  input  logic [7:0]  pad_din,
  output logic        busy
);

  localparam logic [2:0] ADDR_LAST = 3'(ADDR_BEATS - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BEATS - 1);
  localparam logic [2:0] WAIT_LAST =
    (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  state_t      state, state_n;
  logic [2:0]  beat, beat_n;
  txn_t        txn, txn_n;
  logic [23:0] rbuf;
  logic        gnt, gnt_id;

  logic [7:0]  ctl_n, dout_n, oe_n;
  logic        ack0_n, ack1_n, busy_n;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .req1   (req1),
    .take   (state == S_IDLE),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Next state, beat counter and transaction latch
  always_comb begin
    state_n = state;
    beat_n  = beat;
    txn_n   = txn;
    unique case (state)
      S_IDLE: if (gnt) begin
        state_n     = S_ADDR;
        beat_n      = 3'd0;
        txn_n.id    = gnt_id;
        txn_n.we    = gnt_id ? we1 : we0;
        txn_n.addr  = gnt_id ? addr1 : addr0;
        txn_n.wdata = gnt_id ? wdata1 : wdata0;
      end
      S_ADDR: if (beat == ADDR_LAST) begin
        state_n = S_CMD;
        beat_n  = 3'd0;
      end else begin
        beat_n = beat + 3'd1;
      end
      S_CMD: begin
        beat_n  = 3'd0;
        state_n = (WAIT_CYCLES > 0) ? S_WAIT : S_DATA;
      end
      S_WAIT: if (beat == WAIT_LAST) begin
        state_n = S_DATA;
        beat_n  = 3'd0;
      end else begin
        beat_n = beat + 3'd1;
      end
      S_DATA: if (beat == DATA_LAST) begin
        state_n = S_DONE;
        beat_n  = 3'd0;
      end else begin
        beat_n = beat + 3'd1;
      end
      S_DONE: state_n = S_IDLE;
      default: begin
        state_n = S_IDLE;
        beat_n  = 3'd0;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so they can be registered
  always_comb begin
    ctl_n  = '0;
    dout_n = '0;
    oe_n   = '0;
    ack0_n = 1'b0;
    ack1_n = 1'b0;
    busy_n = (state_n != S_IDLE);
    unique case (state_n)
      S_ADDR:
        ctl_n = txn_n.addr[{beat_n[1:0], 3'b000} +: LANE_W];
      S_CMD:
        ctl_n[CMD_WRITE] = txn_n.we;
      S_DATA: if (txn_n.we) begin
        dout_n = txn_n.wdata[{beat_n[1:0], 3'b000} +: LANE_W];
        oe_n   = '1;
      end
      S_DONE: begin
        ack0_n = ~txn_n.id;
        ack1_n = txn_n.id;
      end
      default: ;
    endcase
  end

  // State, transaction and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      beat     <= 3'd0;
      txn      <= '0;
      pad_ctl  <= '0;
      pad_dout <= '0;
      pad_oe   <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      beat     <= beat_n;
      txn      <= txn_n;
      pad_ctl  <= ctl_n;
      pad_dout <= dout_n;
      pad_oe   <= oe_n;
      ack0     <= ack0_n;
      ack1     <= ack1_n;
      busy     <= busy_n;
    end
  end

  // Read bytes arrive LSB first; last beat lands straight in rdata
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbuf  <= '0;
      rdata <= '0;
    end else if (state == S_DATA && !txn.we) begin
      if (beat == DATA_LAST)
        rdata <= {pad_din, rbuf};
      else
        rbuf <= {pad_din, rbuf[23:8]};
    end
  end

endmodule

// File: tb/tb_serial_bus_sequencer.sv
// Directed bench for serial_bus_sequencer.
// dut_a runs WAIT_CYCLES=0, dut_b runs WAIT_CYCLES=3.
module tb_serial_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_a, req1_a, req0_b, req1_b;
  logic        we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [7:0]  pad_din;

  logic        ack0_a, ack1_a, busy_a;
  logic [31:0] rdata_a;
  logic [7:0]  ctl_a, dout_a, oe_a;
  logic        ack0_b, ack1_b, busy_b;
  logic [31:0] rdata_b;
  logic [7:0]  ctl_b, dout_b, oe_b;

  logic        use_b;
  logic        o_ack0, o_ack1, o_busy;
  logic [31:0] o_rdata;
  logic [7:0]  o_ctl, o_dout, o_oe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_bus_sequencer #(.WAIT_CYCLES(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0(req0_a), .req1(req1_a),
    .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0_a), .ack1(ack1_a),
    .rdata(rdata_a), .pad_ctl(ctl_a),
    .pad_dout(dout_a), .pad_oe(oe_a),
    .pad_din(pad_din), .busy(busy_a)
  );

  serial_bus_sequencer #(.WAIT_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0(req0_b), .req1(req1_b),
    .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0_b), .ack1(ack1_b),
    .rdata(rdata_b), .pad_ctl(ctl_b),
    .pad_dout(dout_b), .pad_oe(oe_b),
    .pad_din(pad_din), .busy(busy_b)
  );

  assign o_ack0  = use_b ? ack0_b  : ack0_a;
  assign o_ack1  = use_b ? ack1_b  : ack1_a;
  assign o_busy  = use_b ? busy_b  : busy_a;
  assign o_rdata = use_b ? rdata_b : rdata_a;
  assign o_ctl   = use_b ? ctl_b   : ctl_a;
  assign o_dout  = use_b ? dout_b  : dout_a;
  assign o_oe    = use_b ? oe_b    : oe_a;

  typedef struct {
    logic        sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] din;
    logic [31:0] rdat;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ctl"},  {24'h0, o_ctl},  32'h0);
    chk({tag, " dout"}, {24'h0, o_dout}, 32'h0);
    chk({tag, " oe"},   {24'h0, o_oe},   32'h0);
    chk({tag, " ack0"}, {31'h0, o_ack0}, 32'h0);
    chk({tag, " ack1"}, {31'h0, o_ack1}, 32'h0);
    chk({tag, " busy"}, {31'h0, o_busy}, 32'h0);
    chk({tag, " rdata"}, o_rdata,        32'h0);
  endtask

  task automatic drop_reqs();
    req0_a = 1'b0;
    req1_a = 1'b0;
    req0_b = 1'b0;
  endtask

  // One transaction, checked cycle by cycle up to the idle after ack
  task automatic do_txn(input int w, input logic sel,
                        input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input logic [31:0] din,
                        input logic [31:0] rdat,
                        input bit drop);
    int ack_c, d0;
    bit in_data;
    logic [7:0] e_ctl, e_dout, e_oe;
    string tg;
    use_b = (w != 0);
    ack_c = 10 + w;
    d0    = 6 + w;
    @(negedge clk);
    if (sel) begin
      we1 = we; addr1 = addr; wdata1 = wdata;
    end else begin
      we0 = we; addr0 = addr; wdata0 = wdata;
    end
    if (use_b) req0_b = 1'b1;
    else if (sel) req1_a = 1'b1;
    else req0_a = 1'b1;
    for (int c = 1; c <= ack_c + 1; c++) begin
      @(posedge clk);
      #1;
      tg = $sformatf("w%0d a%h c%0d", w, addr, c);
      e_ctl = 8'h00;
      if (c <= 4) e_ctl = addr[(c-1)*8 +: 8];
      else if (c == 5) e_ctl = {7'b0, we};
      in_data = (c >= d0) && (c < d0 + 4);
      e_oe   = (in_data && we) ? 8'hFF : 8'h00;
      e_dout = (in_data && we) ? wdata[(c-d0)*8 +: 8] : 8'h00;
      chk({tg, " ctl"},  {24'h0, o_ctl},  {24'h0, e_ctl});
      chk({tg, " dout"}, {24'h0, o_dout}, {24'h0, e_dout});
      chk({tg, " oe"},   {24'h0, o_oe},   {24'h0, e_oe});
      chk({tg, " ack0"}, {31'h0, o_ack0},
          {31'h0, (c == ack_c) && !sel});
      chk({tg, " ack1"}, {31'h0, o_ack1},
          {31'h0, (c == ack_c) && sel});
      chk({tg, " busy"}, {31'h0, o_busy},
          {31'h0, c <= ack_c});
      if (!we && c >= ack_c)
        chk({tg, " rdata"}, o_rdata, rdat);
      pad_din = in_data ? din[(c-d0)*8 +: 8] : 8'h5A;
      if ((drop && c == 2) || c == ack_c)
        drop_reqs();
    end
  endtask

  initial begin
    int t, last_t, seen;
    bit exp_id;
    rst_n = 1'b0;
    req0_a = 0; req1_a = 0; req0_b = 0; req1_b = 0;
    we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    pad_din = 8'h00;
    use_b = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 32'h12345678, 32'h0,
                32'hDDCCBBAA, 32'hDDCCBBAA};
    vecs[1] = '{1'b1, 1'b1, 32'h00000004, 32'hCAFEF00D,
                32'h0, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000,
                32'h0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h00000000, 32'h0,
                32'h04030201, 32'h04030201};

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset a");
    use_b = 1'b1;
    chk_all_zero("reset b");
    use_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++)
      do_txn(0, vecs[i].sel, vecs[i].we, vecs[i].addr,
             vecs[i].wdata, vecs[i].din, vecs[i].rdat, 1'b0);

    do_txn(0, 1'b0, 1'b1, 32'hA5A50001, 32'h01020304,
           32'h0, 32'h0, 1'b1);

    do_txn(3, 1'b0, 1'b0, 32'h80000010, 32'h0,
           32'h44332211, 32'h44332211, 1'b0);
    use_b = 1'b0;

    // Reset during DATA beat 2 of a read
    @(negedge clk);
    we0 = 1'b0; addr0 = 32'h0BADF00D; req0_a = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      pad_din = 8'hEE;
    end
    chk("abort busy before", {31'h0, o_busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    req0_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("abort no ack0", {31'h0, o_ack0}, 32'h0);
      chk("abort idle", {31'h0, o_busy}, 32'h0);
    end
    do_txn(0, 1'b0, 1'b0, 32'h55AA55AA, 32'h0,
           32'h87654321, 32'h87654321, 1'b0);

    // Fresh reset so the pointer favours requester 0
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'h00000100; addr1 = 32'h00000200;
    req0_a = 1'b1; req1_a = 1'b1;
    t = 0; last_t = 0;
    for (int n = 0; n < 4; n++) begin
      exp_id = n[0];
      seen = 0;
      for (int k = 0; k < 30 && seen == 0; k++) begin
        @(posedge clk);
        #1;
        t++;
        if (o_ack0 || o_ack1) seen = 1;
      end
      chk($sformatf("cont%0d ack seen", n), seen, 1);
      chk($sformatf("cont%0d ack1", n),
          {31'h0, o_ack1}, {31'h0, exp_id});
      chk($sformatf("cont%0d ack0", n),
          {31'h0, o_ack0}, {31'h0, !exp_id});
      chk($sformatf("cont%0d spacing", n),
          t - last_t, (n == 0) ? 10 : 11);
      last_t = t;
      @(posedge clk);
      #1;
      t++;
      chk($sformatf("cont%0d pulse0", n), {31'h0, o_ack0}, 0);
      chk($sformatf("cont%0d pulse1", n), {31'h0, o_ack1}, 0);
      chk($sformatf("cont%0d idle", n), {31'h0, o_busy}, 0);
    end
    drop_reqs();
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_bus_sequencer.md
SERIAL_BUS_SEQUENCER -- requirements
Module: serial_bus_sequencer

Interface
REQ-001 Parameter WAIT_CYCLES, default 0: idle turnaround cycles between the CMD phase and the DATA phase; legal range is 0..7.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req0 / req1  input  1  transaction request from requester 0 (instruction fetch) or requester 1 (data port); held high until its ack.
REQ-005 we0 / we1  input  1  1 = write, 0 = read; qualified by the matching req.
REQ-006 addr0 / addr1  input  32  byte address; qualified by the matching req.
REQ-007 wdata0 / wdata1  input  32  write data; qualified by the matching req and we.
REQ-008 ack0 / ack1  output  1  one-cycle completion pulse to requester 0 or 1.
REQ-009 rdata  output  32  read data shared by both requesters; valid only in the ack cycle of a read.
REQ-010 pad_ctl  output  8  external address and command byte lane.
REQ-011 pad_dout  output  8  external data lane, driven value.
REQ-012 pad_oe  output  8  data lane output enable (1 = drive).
REQ-013 pad_din  input  8  external data lane, sampled value.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, ADDR (4 beats), CMD (1), WAIT (WAIT_CYCLES beats), DATA (4 beats), DONE (1); a 3-bit beat counter indexes the ADDR and DATA beats.
REQ-016 In IDLE, a rising edge with req0 or req1 high SHALL grant exactly one requester, latch its we/addr/wdata internally, and enter ADDR beat 0.
REQ-017 Arbitration SHALL be round-robin: a sole requester wins; if both request, the one not granted last wins; after reset the last-granted pointer favours req0.
REQ-018 ADDR beat k (k = 0..3) SHALL drive pad_ctl = addr[8k+7:8k], LSB first.
REQ-019 CMD SHALL drive pad_ctl = {7'b0, we}.
REQ-020 pad_ctl SHALL be 0 in all states other than ADDR and CMD.
REQ-021 CMD SHALL go to WAIT if WAIT_CYCLES > 0, otherwise directly to DATA beat 0.
REQ-022 DATA write, beat k: pad_dout = wdata[8k+7:8k] and pad_oe = 8'hFF.
REQ-023 DATA read, beat k: pad_oe = 0; pad_din is sampled at the rising edge ending that beat into rdata[8k+7:8k].
REQ-024 pad_dout and pad_oe SHALL be 0 in every state other than a write DATA beat.
REQ-025 DONE SHALL pulse ack of the granted requester for exactly one cycle, then return to IDLE.
REQ-026 There is one mandatory IDLE cycle between transactions.
REQ-027 Latency, counting the grant edge as cycle 1: ADDR is cycles 1-4, CMD is 5, DATA starts at 6+WAIT_CYCLES, ack occurs at cycle 10+WAIT_CYCLES.
REQ-028 All outputs SHALL be registered.
REQ-029 rdata SHALL hold its value outside the ack cycle; on writes it is don't-care.
REQ-030 req inputs are ignored outside IDLE.
REQ-031 Once granted, a transaction SHALL run to completion even if req drops, and its ack is still pulsed.
REQ-032 A requester still high after its ack SHALL be treated as a new request at the next IDLE and arbitrated normally.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, the beat counter to 0, and the round-robin pointer to favour req0.
REQ-034 rst_n low SHALL immediately clear to 0: ack0, ack1, rdata, pad_ctl, pad_dout, pad_oe, busy.
REQ-035 Reset mid-transaction SHALL abort it with no ack and no further pad activity.
REQ-036 The first possible grant is the first rising edge after rst_n deasserts.

Structure
REQ-037 Package serial_bus_pkg SHALL hold: the FSM state enum, ADDR_BEATS = 4, DATA_BEATS = 4, CMD_WRITE bit position 0, and the byte-lane width of 8.
REQ-038 One sub-module, rr_arbiter2, SHALL implement the two-way round-robin grant plus last-granted pointer; it is instantiated once.

Verification
REQ-039 Read, WAIT_CYCLES=0: req0=1, we0=0, addr0=32'h12345678, pad_din=AA,BB,CC,DD in DATA beats 0-3 -> pad_ctl=78,56,34,12,00; ack0 at cycle 10; rdata=32'hDDCCBBAA.
REQ-040 Write: req1=1, we1=1, wdata1=32'hCAFEF00D -> CMD byte 01; pad_dout=0D,F0,FE,CA with pad_oe=FF for 4 cycles; ack1 pulse; pad_oe=0 afterwards.
REQ-041 Contention: req0 and req1 held high continuously -> grants alternate 0,1,0,1; each ack is exactly 1 cycle; one IDLE cycle between transactions.
REQ-042 WAIT_CYCLES=3 read -> pad_ctl=0 and pad_oe=0 for 3 cycles after CMD; ack at cycle 13.
REQ-043 Reset abort: rst_n low during DATA beat 2 -> all outputs 0 the same cycle; no ack; next request gets ack at cycle 10.
REQ-044 Early drop: req0 deasserted during ADDR beat 1 -> transaction completes and ack0 still pulses.
